// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the register file write port
// Optional pending-write scoreboard enabled by macro WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      wb_stall,
  output logic                      wb_we,
  output logic [ADDR_W-1:0]         wb_rd,
  output logic [DATA_W-1:0]         wb_data,
  output logic [15:0]               conflict_cnt,
  input  logic                      iss_valid,
  input  logic [ADDR_W-1:0]         iss_rd,
  input  logic [ADDR_W-1:0]         rs1,
  input  logic [ADDR_W-1:0]         rs2,
  output logic                      hazard
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [NUM_REQ-1:0] scan_bit;
  int                 scan_idx;
  logic [ADDR_W-1:0]  sel_rd;
  logic [DATA_W-1:0]  sel_data;
  logic               multi_valid;

  // Scan from rr_ptr upward; ready is also held low while in reset.
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    scan_bit  = '0;
    if (rst_n && !wb_stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
        scan_bit = NUM_REQ'(1) << scan_idx;
        if (!gnt_any && (|(req_valid & scan_bit))) begin
          gnt_any   = 1'b1;
          gnt_idx   = PTR_W'(scan_idx);
          req_ready = scan_bit;
        end
      end
    end
  end

  assign sel_rd      = ADDR_W'(req_rd >> (int'(gnt_idx) * ADDR_W));
  assign sel_data    = DATA_W'(req_data >> (int'(gnt_idx) * DATA_W));
  assign multi_valid = ($countones(req_valid) >= 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      wb_we        <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      conflict_cnt <= '0;
    end else begin
      wb_we <= 1'b0;
      if (gnt_any) begin
        rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        // Writes to x0 are consumed here so the register file never sees them.
        if (sel_rd != '0) begin
          wb_we   <= 1'b1;
          wb_rd   <= sel_rd;
          wb_data <= sel_data;
        end
      end
      if (multi_valid && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Clear before set so a same-cycle issue to the retiring index stays pending.
  always_comb begin
    busy_nxt = busy;
    if (gnt_any) begin
      busy_nxt[sel_rd] = 1'b0;
    end
    if (iss_valid && iss_rd != '0) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign hazard = busy[rs1] | busy[rs2];
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_rd, rs1, rs2};
  assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized bench with behavioural model for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_rd;
  logic [NR*DW-1:0] req_data;
  logic             wb_stall;
  logic             wb_we;
  logic [AW-1:0]    wb_rd;
  logic [DW-1:0]    wb_data;
  logic [15:0]      conflict_cnt;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd;
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic             hazard;

  logic [AW-1:0]    rd_a  [NR];
  logic [DW-1:0]    dat_a [NR];

  int checks = 0;
  int errors = 0;

  // model state: what the outputs must show after the most recent edge
  int          m_ptr;
  bit          m_we;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  int          m_cnt;
  bit          m_busy [32];
  int          m_gnt = -1;

  regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data), .wb_stall(wb_stall), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .conflict_cnt(conflict_cnt),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2), .hazard(hazard)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_rd   = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) begin
      req_rd[i*AW +: AW]   = rd_a[i];
      req_data[i*DW +: DW] = dat_a[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int g;
    int idx;
    int nv;
    logic [NR-1:0] er;
    bit eh;
    if (!rst_n) begin
      m_ptr = 0; m_we = 0; m_rd = '0; m_data = '0; m_cnt = 0; m_gnt = -1;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      chk("mdl_rst_ready", req_ready, 0);
      chk("mdl_rst_we", wb_we, 0);
      chk("mdl_rst_cnt", conflict_cnt, 0);
    end else begin
      g = -1;
      nv = 0;
      for (int i = 0; i < NR; i++) nv += int'(req_valid[i]);
      if (!wb_stall) begin
        for (int k = 0; k < NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      eh = SB && (m_busy[rs1] || m_busy[rs2]);
      chk("mdl_ready", req_ready, er);
      chk("mdl_wb_we", wb_we, m_we);
      chk("mdl_wb_rd", wb_rd, m_rd);
      chk("mdl_wb_data", wb_data, m_data);
      chk("mdl_cnt", conflict_cnt, m_cnt);
      chk("mdl_hazard", hazard, eh);
      m_we = 0;
      if (g >= 0) begin
        m_ptr = (g + 1) % NR;
        m_busy[rd_a[g]] = 1'b0;
        if (rd_a[g] != 0) begin
          m_we = 1; m_rd = rd_a[g]; m_data = dat_a[g];
        end
      end
      if (nv >= 2 && m_cnt < 65535) m_cnt++;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      m_busy[0] = 1'b0;
      m_gnt = g;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; wb_stall = 1'b0;
    iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
    for (int i = 0; i < NR; i++) begin rd_a[i] = '0; dat_a[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single request
    rd_a[0] = 5; dat_a[0] = 32'hDEADBEEF; req_valid = 2'b01;
    @(negedge clk); chk("single_ready", req_ready, 2'b01);
    step(); req_valid = '0;
    @(negedge clk);
    chk("single_we", wb_we, 1); chk("single_rd", wb_rd, 5); chk("single_data", wb_data, 32'hDEADBEEF);
    step();
    @(negedge clk); chk("single_we_off", wb_we, 0);

    // contention from a fresh pointer
    do_reset();
    rd_a[0] = 1; dat_a[0] = 32'hA0; rd_a[1] = 2; dat_a[1] = 32'hB1; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_ready", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk("cont_wb_rd", wb_rd, ((i - 1) % 2 == 0) ? 1 : 2);
      step();
    end
    req_valid = '0;
    @(negedge clk);
    chk("cont_wb_rd_last", wb_rd, 2); chk("cont_cnt", conflict_cnt, 4);

    // x0 write, then stall holding the pointer
    step();
    rd_a[0] = 0; dat_a[0] = 32'h1111; req_valid = 2'b01;
    @(negedge clk); chk("x0_ready", req_ready, 2'b01);
    step();
    rd_a[0] = 3; dat_a[0] = 32'h3333; rd_a[1] = 4; dat_a[1] = 32'h4444;
    req_valid = 2'b11; wb_stall = 1'b1;
    @(negedge clk);
    chk("x0_we", wb_we, 0); chk("x0_rd_hold", wb_rd, 2); chk("stall_ready", req_ready, 0);
    step();
    @(negedge clk); chk("stall_ready2", req_ready, 0);
    step(); wb_stall = 1'b0;
    @(negedge clk); chk("resume_ready", req_ready, 2'b10);
    step(); req_valid = 2'b01;
    @(negedge clk);
    chk("resume_we", wb_we, 1); chk("resume_rd", wb_rd, 4); chk("resume_next", req_ready, 2'b01);

    // asynchronous reset with a transfer in flight
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", req_ready, 0); chk("arst_we", wb_we, 0); chk("arst_rd", wb_rd, 0);
    chk("arst_data", wb_data, 0); chk("arst_cnt", conflict_cnt, 0);
    req_valid = '0;
    @(negedge clk);
    step(); rst_n = 1'b1;

    // randomized traffic under the requester hold rule
    for (int n = 0; n < 1500; n++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || m_gnt == i) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          rd_a[i]      = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
          dat_a[i]     = $urandom;
        end
      end
      wb_stall  = ($urandom_range(0, 3) == 0);
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = AW'($urandom_range(0, 31));
      rs1       = AW'($urandom_range(0, 31));
      rs2       = AW'($urandom_range(0, 31));
    end
    step();
    wb_stall = 1'b0; iss_valid = 1'b0; req_valid = '0;

    // counter saturation
    step();
    rd_a[0] = 9; rd_a[1] = 10; req_valid = 2'b11;
    repeat (70000) step();
    @(negedge clk); chk("sat_cnt", conflict_cnt, 16'hFFFF);
    repeat (5) step();
    @(negedge clk); chk("sat_hold", conflict_cnt, 16'hFFFF);

    // scoreboard set / clear / set-wins
    step(); req_valid = '0;
    do_reset();
    iss_valid = 1'b1; iss_rd = 7; rs1 = 7; rs2 = 0;
    @(negedge clk); chk("sb_before", hazard, 0);
    step(); iss_valid = 1'b0; rd_a[0] = 7; dat_a[0] = 32'h77; req_valid = 2'b01;
    @(negedge clk); chk("sb_set", hazard, SB);
    step(); req_valid = '0;
    @(negedge clk); chk("sb_clear", hazard, 0);
    step(); iss_valid = 1'b1;
    step(); req_valid = 2'b01;
    @(negedge clk); chk("sb_reset", hazard, SB);
    step(); iss_valid = 1'b0; req_valid = '0;
    @(negedge clk); chk("sb_set_wins", hazard, SB);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
